matmul_rr_scheduler: RTL and testbench
======================================

Name: matmul_rr_scheduler

Overview:
Round-robin scheduler that shares one iterative 5x2 by 2x3 matrix multiplier engine between two requesters. Each requester holds a level request with its operands. The scheduler does four things in turn: grants one requester, pulses the engine start, waits for the engine finished flag (guarded by a watchdog), then captures the 225-bit result and returns it with a one-cycle done pulse. It sits between the requesting datapath blocks and the multiplier engine.

Parameters:
TIMEOUT, 64, max cycles in WAIT before the job is aborted with error (must be >= 16, since the engine needs 15 compute cycles)
TW, 7, width of the watchdog counter (must hold TIMEOUT)

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
Req0  input  1  requester 0 level request; held until Done0
MatrixA0  input  150  requester 0 A operand (5x2, 15b each, row-major, [0][0] in MSBs)
MatrixB0  input  90  requester 0 B operand (2x3, 15b each, row-major)
Req1  input  1  requester 1 level request
MatrixA1  input  150  requester 1 A operand
MatrixB1  input  90  requester 1 B operand
Done0  output  1  one-cycle pulse, requester 0 job complete (result or error)
Done1  output  1  one-cycle pulse, requester 1 job complete
Error  output  1  valid with DoneN; 1 = job aborted by watchdog
MatrixResult  output  225  captured result (5x3, 15b each), held until next capture
Busy  output  1  high whenever the FSM is not in IDLE
EngStart  output  1  engine start, high exactly one cycle per job
EngMatrixA  output  150  operand A to engine
EngMatrixB  output  90  operand B to engine
EngResult  input  225  engine result
EngFinished  input  1  engine finished flag (level)

Behaviour:
- Reset (async, any state): FSM to IDLE. Done0, Done1, Error, EngStart, Busy = 0. MatrixResult = 0. Watchdog = 0. Last-grant pointer = 1, so requester 0 wins first.
- Grant: registered 1-bit gnt, changed only in IDLE. EngMatrixA/B = gnt ? A1/B1 : A0/B0, combinational. The requester must hold its operands stable while its Req is high.
- FSM:
  - IDLE: if any Req is high, pick one round-robin: the requester that is not the last granted has priority when both are high. Load gnt, go to START.
  - START: EngStart = 1 for this cycle only. Clear the watchdog, go to SETTLE.
  - SETTLE: one cycle ignoring EngFinished, which may still be stale from the previous job. Go to WAIT.
  - WAIT: increment the watchdog each cycle.
    - If EngFinished = 1: MatrixResult <= EngResult, Error <= 0, go to DONE.
    - Else if watchdog == TIMEOUT-1: MatrixResult unchanged, Error <= 1, go to DONE.
    - Finished wins over timeout in the same cycle.
  - DONE: Done[gnt] = 1 for one cycle, Error valid this cycle. Update last-grant pointer <= gnt, go to IDLE.
- Latency:
  - Request seen in IDLE at edge N gives EngStart during cycle N+1 (START).
  - EngFinished sampled at edge M in WAIT gives Done during cycle M+1.
  - Minimum gap between jobs: one IDLE cycle.
- Req dropped mid-job: the job still completes and Done still pulses; the requester ignores it.
- Both Req held continuously: grants strictly alternate 0,1,0,1...
- Error is registered, is 0 outside the DONE cycle, and never coincides with MatrixResult changing.
- No arithmetic in this block; widths pass through unchanged.

Test Plan:
- Single job, Req0 only: A0 all elements = 1, B0 all elements = 2, engine model raises finished 15 cycles after start -> EngStart one pulse, Done0 one pulse, Error = 0, MatrixResult = every element 4, Done1 never high.
- Both Req rise in the same cycle after reset -> requester 0 served first, then requester 1. EngStart pulses exactly twice. Done0 precedes Done1. MatrixResult reflects job 1 after Done1.
- Both Req held for 6 jobs -> grant order 0,1,0,1,0,1, with exactly one IDLE cycle between each DONE and the next START.
- Engine never finishes, TIMEOUT = 64 -> Done0 and Error = 1 exactly 64 WAIT cycles after SETTLE. MatrixResult keeps its previous value. A following job completes normally with Error = 0.
- EngFinished held high (stale) during START and SETTLE, then low, then high at WAIT cycle 10 -> capture occurs only at that WAIT cycle and not in SETTLE.
- Reset asserted during WAIT -> all outputs 0 immediately (asynchronous), FSM in IDLE. After release with Req1 high, requester 1 is served but requester 0 still has priority on a tie.

Source files
------------

// File: rtl/matmul_rr_scheduler.sv
// Round-robin scheduler sharing one iterative 5x2 * 2x3 matrix multiplier between two requesters.
// It grants one requester, pulses the engine start, waits for the engine finished flag under a
// watchdog, then captures the 225-bit result and returns it with a one-cycle done pulse.
//
// Ports:
//   Clk, Reset            clock and asynchronous active-high reset
//   Req0/Req1             level requests, held until the matching Done pulse
//   MatrixA0/1, MatrixB0/1 requester operands (15-bit elements, row-major, [0][0] in MSBs)
//   Done0/Done1           one-cycle completion pulse for the granted requester
//   Error                 valid with DoneN; 1 = job aborted by the watchdog
//   MatrixResult          last captured result, held until the next capture
//   Busy                  high whenever the scheduler is not idle
//   EngStart              one-cycle engine start per job
//   EngMatrixA/B          operands routed from the granted requester
//   EngResult/EngFinished engine result and level finished flag
module matmul_rr_scheduler #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned TW      = 7
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Req0,
   input  logic [149:0] MatrixA0,
   input  logic [89:0]  MatrixB0,
   input  logic         Req1,
   input  logic [149:0] MatrixA1,
   input  logic [89:0]  MatrixB1,
   output logic         Done0,
   output logic         Done1,
   output logic         Error,
   output logic [224:0] MatrixResult,
   output logic         Busy,
   output logic         EngStart,
   output logic [149:0] EngMatrixA,
   output logic [89:0]  EngMatrixB,
   input  logic [224:0] EngResult,
   input  logic         EngFinished
);

   typedef enum logic [2:0] {StIdle, StStart, StSettle, StWait, StDone} state_e;

   state_e         state_q, state_d;
   logic           gnt_q, gnt_d;
   logic           last_q, last_d;
   logic [TW-1:0]  wdog_q, wdog_d;
   logic [224:0]   result_q, result_d;
   logic           error_q, error_d;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= StIdle;
         gnt_q    <= 1'b0;
         last_q   <= 1'b1;  // requester 0 wins the first tie
         wdog_q   <= '0;
         result_q <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
         wdog_q   <= wdog_d;
         result_q <= result_d;
         error_q  <= error_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      wdog_d   = wdog_q;
      result_d = result_q;
      error_d  = error_q;
      unique case (state_q)
         StIdle: begin
            if (Req0 && Req1) begin
               gnt_d   = ~last_q;  // the requester not served last has priority
               state_d = StStart;
            end else if (Req0) begin
               gnt_d   = 1'b0;
               state_d = StStart;
            end else if (Req1) begin
               gnt_d   = 1'b1;
               state_d = StStart;
            end
         end
         StStart: begin
            wdog_d  = '0;
            state_d = StSettle;
         end
         // EngFinished may still be high from the previous job here, so it is not looked at.
         StSettle: state_d = StWait;
         StWait: begin
            wdog_d = wdog_q + TW'(1);
            if (EngFinished) begin
               result_d = EngResult;
               error_d  = 1'b0;
               state_d  = StDone;
            end else if (wdog_q == TW'(TIMEOUT - 1)) begin
               error_d  = 1'b1;
               state_d  = StDone;
            end
         end
         StDone: begin
            last_d  = gnt_q;
            error_d = 1'b0;  // Error is only meaningful during the done cycle
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign Busy         = (state_q != StIdle);
   assign EngStart     = (state_q == StStart);
   assign Done0        = (state_q == StDone) && !gnt_q;
   assign Done1        = (state_q == StDone) && gnt_q;
   assign Error        = error_q;
   assign MatrixResult = result_q;
   assign EngMatrixA   = gnt_q ? MatrixA1 : MatrixA0;
   assign EngMatrixB   = gnt_q ? MatrixB1 : MatrixB0;

endmodule

// File: tb/tb_matmul_rr_scheduler.sv
// Self-checking bench for matmul_rr_scheduler: a behavioural engine model plus a job-level
// reference that predicts grants, done timing, error and the result matrix.
module tb_matmul_rr_scheduler;

   localparam int unsigned TIMEOUT = 64;
   localparam int unsigned TW      = 7;

   logic         Clk = 1'b0;
   logic         Reset = 1'b0;
   logic         Req0 = 1'b0, Req1 = 1'b0;
   logic [149:0] A0 = '0, A1 = '0;
   logic [89:0]  B0 = '0, B1 = '0;
   logic         Done0, Done1, Error, Busy, EngStart, EngFinished;
   logic [224:0] MatrixResult, EngResult;
   logic [149:0] EngMatrixA;
   logic [89:0]  EngMatrixB;

   matmul_rr_scheduler #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .Clk(Clk), .Reset(Reset),
      .Req0(Req0), .MatrixA0(A0), .MatrixB0(B0),
      .Req1(Req1), .MatrixA1(A1), .MatrixB1(B1),
      .Done0(Done0), .Done1(Done1), .Error(Error), .MatrixResult(MatrixResult),
      .Busy(Busy), .EngStart(EngStart), .EngMatrixA(EngMatrixA), .EngMatrixB(EngMatrixB),
      .EngResult(EngResult), .EngFinished(EngFinished)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [224:0] got, input logic [224:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Plain matrix product, 15-bit wrap-around arithmetic.
   function automatic logic [224:0] matmul(input logic [149:0] a, input logic [89:0] b);
      logic [224:0] c;
      logic [14:0]  s;
      c = '0;
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 3; j++) begin
            s = '0;
            for (int k = 0; k < 2; k++)
               s = s + a[149 - 15 * (i * 2 + k) -: 15] * b[89 - 15 * (k * 3 + j) -: 15];
            c[224 - 15 * (i * 3 + j) -: 15] = s;
         end
      end
      return c;
   endfunction

   task automatic rand_ops(output logic [149:0] a, output logic [89:0] b);
      for (int i = 0; i < 10; i++) a[149 - 15 * i -: 15] = 15'($urandom);
      for (int i = 0; i < 6; i++) b[89 - 15 * i -: 15] = 15'($urandom);
   endtask

   // Engine model: finished (level) rises eng_del edges after the start is taken and stays
   // high until the next start; optional stale mode also holds it high in the cycle after start.
   int           eng_delay_cfg = 15;
   bit           eng_stale_cfg = 1'b0;
   bit           eng_run, eng_stale;
   int           eng_t, eng_del;
   logic [224:0] eng_prod, eng_old;

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         eng_run <= 1'b0; eng_t <= 0; eng_del <= 0; eng_stale <= 1'b0;
         eng_prod <= '0; eng_old <= '0;
      end else if (EngStart) begin
         eng_run   <= 1'b1;
         eng_t     <= 0;
         eng_del   <= eng_delay_cfg;
         eng_stale <= eng_stale_cfg;
         eng_prod  <= matmul(EngMatrixA, EngMatrixB);
         eng_old   <= EngResult;
      end else if (eng_run && eng_t < 10000) begin
         eng_t <= eng_t + 1;
      end
   end

   assign EngResult   = (eng_run && eng_t >= eng_del) ? eng_prod : eng_old;
   assign EngFinished = eng_run && ((eng_t >= eng_del) || (eng_stale && eng_t == 0));

   // Reference model, evaluated once per cycle away from the active edge.
   int           cyc = 0;
   bit           job_act = 1'b0, mon_g = 1'b0, mon_err = 1'b0, exp_last = 1'b1;
   bit           was_idle = 1'b1, rq0_p = 1'b0, rq1_p = 1'b0;
   int           mon_start_cyc, mon_done_cyc, mon_w;
   int           last_done = -1, last_interval = 0;
   int           n_start = 0, n_done0 = 0, n_done1 = 0;
   logic [224:0] exp_res = '0, mon_job_res = '0;
   int           grants[$];
   int           gaps[$];

   always @(negedge Clk) begin
      bit idle_now;
      cyc = cyc + 1;
      if (Reset) begin
         job_act = 1'b0; exp_last = 1'b1; exp_res = '0; was_idle = 1'b1;
         rq0_p = 1'b0; rq1_p = 1'b0; last_done = -1;
      end else begin
         n_start = n_start + int'(EngStart);
         n_done0 = n_done0 + int'(Done0);
         n_done1 = n_done1 + int'(Done1);
         idle_now = !job_act && !EngStart;
         if (!job_act) begin
            if (EngStart) begin
               check("start_busy", 225'(Busy), 225'(1));
               check("start_after_idle", 225'(was_idle), 225'(1));
               if (!rq0_p && !rq1_p) check("start_without_req", 225'(0), 225'(1));
               if (rq0_p && rq1_p) mon_g = !exp_last;
               else mon_g = rq1_p;
               check("grant_op_a", 225'(EngMatrixA), mon_g ? 225'(A1) : 225'(A0));
               check("grant_op_b", 225'(EngMatrixB), mon_g ? 225'(B1) : 225'(B0));
               if (last_done >= 0) gaps.push_back(cyc - last_done);
               grants.push_back(int'(mon_g));
               mon_w = (eng_delay_cfg > int'(TIMEOUT)) ? int'(TIMEOUT) :
                       (eng_delay_cfg < 1 ? 1 : eng_delay_cfg);
               mon_err = (eng_delay_cfg > int'(TIMEOUT));
               mon_job_res = mon_g ? matmul(A1, B1) : matmul(A0, B0);
               mon_start_cyc = cyc;
               mon_done_cyc = cyc + 2 + mon_w;
               job_act = 1'b1;
            end else begin
               check("idle_quiet", 225'({Busy, Done0, Done1, Error}), 225'(0));
               if (was_idle && (rq0_p || rq1_p)) check("start_latency", 225'(0), 225'(1));
            end
         end else if (cyc == mon_done_cyc) begin
            check("done_pulse", 225'({Busy, EngStart, Done0, Done1, Error}),
                  225'({1'b1, 1'b0, !mon_g, mon_g, mon_err}));
            if (!mon_err) exp_res = mon_job_res;
            exp_last = mon_g;
            last_done = cyc;
            last_interval = cyc - mon_start_cyc;
            job_act = 1'b0;
         end else begin
            check("job_running", 225'({Busy, EngStart, Done0, Done1, Error}), 225'(5'b10000));
         end
         check("result_hold", MatrixResult, exp_res);
         was_idle = idle_now;
         rq0_p = Req0;
         rq1_p = Req1;
      end
   end

   task automatic wait_done(output bit who);
      bit got = 1'b0;
      who = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge Clk);
         if (Done0 || Done1) begin
            got = 1'b1;
            who = Done1;
         end
      end
      if (!got) check("done_timeout", 225'(0), 225'(1));
   endtask

   task automatic apply_reset();
      @(posedge Clk);
      #2 Reset = 1'b1;
      @(posedge Clk);
      #1 Reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit           who, d0, d1, got;
      logic [224:0] fours, prev;

      #1 Reset = 1'b1;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      check("reset_outputs", 225'({Busy, EngStart, Done0, Done1, Error}), 225'(0));
      check("reset_result", MatrixResult, 225'(0));
      @(posedge Clk);
      #1 Reset = 1'b0;

      // Single job, A all 1, B all 2: every result element is 4.
      for (int i = 0; i < 10; i++) A0[149 - 15 * i -: 15] = 15'd1;
      for (int i = 0; i < 6; i++) B0[89 - 15 * i -: 15] = 15'd2;
      for (int i = 0; i < 15; i++) fours[224 - 15 * i -: 15] = 15'd4;
      eng_delay_cfg = 15;
      @(posedge Clk);
      #1 n_start = 0; n_done0 = 0; n_done1 = 0; Req0 = 1'b1;
      wait_done(who);
      check("s1_who", 225'(who), 225'(0));
      check("s1_error", 225'(Error), 225'(0));
      check("s1_result_fours", MatrixResult, fours);
      @(posedge Clk);
      #1 Req0 = 1'b0;
      repeat (3) @(posedge Clk);
      check("s1_starts", 225'(n_start), 225'(1));
      check("s1_done0", 225'(n_done0), 225'(1));
      check("s1_done1", 225'(n_done1), 225'(0));

      // Both requests rise together after reset: 0 then 1.
      apply_reset();
      rand_ops(A0, B0);
      rand_ops(A1, B1);
      #1 n_start = 0; Req0 = 1'b1; Req1 = 1'b1;
      wait_done(who);
      check("s2_first", 225'(who), 225'(0));
      @(posedge Clk);
      #1 Req0 = 1'b0;
      wait_done(who);
      check("s2_second", 225'(who), 225'(1));
      check("s2_result", MatrixResult, matmul(A1, B1));
      @(posedge Clk);
      #1 Req1 = 1'b0;
      repeat (3) @(posedge Clk);
      check("s2_starts", 225'(n_start), 225'(2));

      // Both held for six jobs: strict alternation, one idle cycle between jobs.
      apply_reset();
      #1 grants.delete(); gaps.delete();
      eng_delay_cfg = $urandom_range(1, 20);
      Req0 = 1'b1; Req1 = 1'b1;
      for (int j = 0; j < 6; j++) begin
         wait_done(who);
         @(posedge Clk);
         #1 eng_delay_cfg = $urandom_range(1, 20);
      end
      Req0 = 1'b0; Req1 = 1'b0;
      repeat (3) @(posedge Clk);
      check("s3_njobs", 225'(grants.size()), 225'(6));
      for (int j = 0; j < grants.size(); j++) check("s3_order", 225'(grants[j]), 225'(j % 2));
      check("s3_ngaps", 225'(gaps.size()), 225'(5));
      for (int j = 0; j < gaps.size(); j++) check("s3_gap", 225'(gaps[j]), 225'(2));

      // Engine never finishes: watchdog abort, result held, then a normal job.
      #1 eng_delay_cfg = 1000;
      prev = MatrixResult;
      Req0 = 1'b1;
      wait_done(who);
      check("s4_who", 225'(who), 225'(0));
      check("s4_error", 225'(Error), 225'(1));
      check("s4_result_held", MatrixResult, prev);
      @(posedge Clk);
      #1 Req0 = 1'b0;
      check("s4_wait_len", 225'(last_interval), 225'(2 + TIMEOUT));
      eng_delay_cfg = 10;
      rand_ops(A1, B1);
      Req1 = 1'b1;
      wait_done(who);
      check("s4_next_who", 225'(who), 225'(1));
      check("s4_next_error", 225'(Error), 225'(0));
      check("s4_next_result", MatrixResult, matmul(A1, B1));
      @(posedge Clk);
      #1 Req1 = 1'b0;

      // Stale finished during start/settle; real finish at wait cycle 10.
      eng_delay_cfg = 5;
      rand_ops(A0, B0);
      Req0 = 1'b1;
      wait_done(who);
      @(posedge Clk);
      #1 Req0 = 1'b0;
      eng_stale_cfg = 1'b1;
      eng_delay_cfg = 11;
      rand_ops(A1, B1);
      Req1 = 1'b1;
      wait_done(who);
      check("s5_who", 225'(who), 225'(1));
      check("s5_result", MatrixResult, matmul(A1, B1));
      @(posedge Clk);
      #1 Req1 = 1'b0;
      eng_stale_cfg = 1'b0;
      check("s5_interval", 225'(last_interval), 225'(13));

      // Reset during WAIT: outputs clear at once, pointer back to favouring requester 0.
      eng_delay_cfg = 1000;
      rand_ops(A0, B0);
      Req0 = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge Clk);
         got = EngStart;
      end
      if (!got) check("s6_start_timeout", 225'(0), 225'(1));
      repeat (10) @(posedge Clk);
      #2 Reset = 1'b1;
      #1 check("s6_async_outputs", 225'({Busy, EngStart, Done0, Done1, Error}), 225'(0));
      check("s6_async_result", MatrixResult, 225'(0));
      Req0 = 1'b0;
      @(posedge Clk);
      #1 Reset = 1'b0;
      eng_delay_cfg = 8;
      rand_ops(A0, B0);
      rand_ops(A1, B1);
      Req0 = 1'b1; Req1 = 1'b1;
      wait_done(who);
      check("s6_tie_after_reset", 225'(who), 225'(0));
      @(posedge Clk);
      #1 Req0 = 1'b0;
      wait_done(who);
      check("s6_req1_served", 225'(who), 225'(1));
      @(posedge Clk);
      #1 Req1 = 1'b0;

      // Random traffic; the reference model checks every cycle.
      for (int c = 0; c < 1500; c++) begin
         @(negedge Clk);
         d0 = Done0; d1 = Done1;
         @(posedge Clk);
         #1;
         if (d0) Req0 = 1'b0;
         else if (!Req0 && $urandom_range(0, 3) == 0) begin rand_ops(A0, B0); Req0 = 1'b1; end
         if (d1) Req1 = 1'b0;
         else if (!Req1 && $urandom_range(0, 3) == 0) begin rand_ops(A1, B1); Req1 = 1'b1; end
         eng_delay_cfg = ($urandom_range(0, 9) == 0) ? 100 : int'($urandom_range(1, 30));
         eng_stale_cfg = 1'($urandom_range(0, 1));
      end
      got = 1'b0;
      for (int c = 0; c < 1000 && !got; c++) begin
         @(negedge Clk);
         d0 = Done0; d1 = Done1;
         @(posedge Clk);
         #1;
         if (d0) Req0 = 1'b0;
         if (d1) Req1 = 1'b0;
         got = !Req0 && !Req1;
      end
      check("drain", 225'(got), 225'(1));

      repeat (3) @(posedge Clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
